// File: rtl/alu_result_tx.sv
// ALU result serialiser: byte FIFO feeding an 8N1 UART-style transmitter.
// Define ALU_TX_PARITY_EN to add an even-parity bit after the data bits.
module alu_result_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] res_data,
    input  logic       res_valid,
    output logic       res_ready,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ALU_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [4:0]      count;
    logic            run;
    logic            push;
    logic            pop;
    logic            bit_end;
`ifdef ALU_TX_PARITY_EN
    logic            par;
`endif

    // run holds res_ready low until the first edge after reset release
    assign res_ready  = ena & run & (count < DEPTH5);
    assign push       = res_valid & res_ready;
    assign bit_end    = (cnt == BIT_LAST);
    assign fifo_count = count;
    assign busy       = (state != IDLE) | (count != 5'd0);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ena && count != 5'd0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef ALU_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef ALU_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (ena && count != 5'd0) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
`ifdef ALU_TX_PARITY_EN
            PARITY:  tx = par;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (state == IDLE || state_nxt != state || bit_end) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // bit_idx wraps 7 -> 0 naturally as the last data bit ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (pop) begin
                shreg <= mem[rd_ptr];
            end else if (state == DATA && bit_end) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

`ifdef ALU_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (pop) begin
            par <= ^mem[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res_data;
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx: line-level model plus
// directed frame, stall, back-to-back, parity, reset and ena-drop cases.
module tb_alu_result_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef ALU_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_result_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .tx(tx), .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: pending bytes, and the line as a queue of per-cycle tx values
    logic [7:0] m_q[$];
    bit         m_line[$];
    bit         m_run = 1'b0;

    task automatic load(input logic [7:0] d);
        repeat (C) m_line.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (C) m_line.push_back(d[i]);
`ifdef ALU_TX_PARITY_EN
        repeat (C) m_line.push_back(^d);
`endif
        repeat (C) m_line.push_back(1'b1);
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit rdy;
        bit do_push;
        if (!rst_n) begin
            m_q.delete();
            m_line.delete();
            m_run = 1'b0;
        end else begin
            rdy     = ena && m_run && (m_q.size() < DEPTH);
            do_push = res_valid && rdy;
            if (m_line.size() > 0) void'(m_line.pop_front());
            if (m_line.size() == 0 && ena && m_q.size() > 0)
                load(m_q.pop_front());
            if (do_push) m_q.push_back(res_data);
            m_run = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit e_tx;
        e_tx = (m_line.size() > 0) ? m_line[0] : 1'b1;
        chk("m_tx", 32'(tx), 32'(e_tx));
        chk("m_busy", 32'(busy),
            32'((m_line.size() > 0) || (m_q.size() > 0)));
        chk("m_count", 32'(fifo_count), 32'(m_q.size()));
        chk("m_ready", 32'(res_ready),
            32'(ena && m_run && (m_q.size() < DEPTH)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        res_data  = d;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    // Push into an idle block and sample every bit at mid-bit
    task automatic capture(input logic [7:0] d, output logic [10:0] frm,
                           output logic b_last, output logic b_after);
        frm = '0;
        b_last = 1'b0;
        b_after = 1'b1;
        push(d);
        for (int k = -1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k >= 0 && k < FRAME && (k % C) == C / 2) frm[k / C] = tx;
            if (k == FRAME - 1) b_last = busy;
            if (k == FRAME) b_after = busy;
        end
    endtask

    task automatic wait_idle(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk("wait_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [10:0] frm;
        logic        bl;
        logic        ba;
        int          peak;
        logic        rdy_pk;
        bit          ok;

        rst_n = 1'b1; ena = 1'b0; res_valid = 1'b0; res_data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(res_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 ena = 1'b1;
        #1 chk("ready_in_rst", 32'(res_ready), 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("ready_pre_edge", 32'(res_ready), 32'd0);
        tick();
        chk("ready_post_edge", 32'(res_ready), 32'd1);

        capture(8'hA5, frm, bl, ba);
`ifdef ALU_TX_PARITY_EN
        chk("frame_a5", 32'(frm), 32'h54A);
`else
        chk("frame_a5", 32'(frm), 32'h34A);
`endif
        chk("busy_last_stop", 32'(bl), 32'd1);
        chk("busy_after_stop", 32'(ba), 32'd0);

        ena = 1'b0;
        res_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_data = 8'(8'h10 + i);
            tick();
            if (res_ready !== 1'b0 || fifo_count !== 5'd0) ok = 1'b0;
        end
        res_valid = 1'b0;
        chk("stall_no_accept", 32'(ok), 32'd1);
        chk("stall_count", 32'(fifo_count), 32'd0);
        ena = 1'b1;
        tick();

        peak = 0;
        rdy_pk = 1'b1;
        res_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            res_data = 8'(i);
            tick();
            if (int'(fifo_count) > peak) begin
                peak = int'(fifo_count);
                rdy_pk = res_ready;
            end
        end
        res_valid = 1'b0;
        chk("b2b_peak", 32'(peak), 32'd4);
        chk("b2b_ready_at_peak", 32'(rdy_pk), 32'd0);
        wait_idle(6 * FRAME + 20);

        capture(8'hFF, frm, bl, ba);
`ifdef ALU_TX_PARITY_EN
        chk("frame_ff", 32'(frm), 32'h5FE);
        chk("par_ff", 32'(frm[9]), 32'd0);
`else
        chk("frame_ff", 32'(frm), 32'h3FE);
`endif
        capture(8'h00, frm, bl, ba);
`ifdef ALU_TX_PARITY_EN
        chk("frame_00", 32'(frm), 32'h400);
        chk("par_00", 32'(frm[9]), 32'd0);
`else
        chk("frame_00", 32'(frm), 32'h200);
`endif
        capture(8'h07, frm, bl, ba);
`ifdef ALU_TX_PARITY_EN
        chk("frame_07", 32'(frm), 32'h60E);
        chk("par_07", 32'(frm[9]), 32'd1);
`else
        chk("frame_07", 32'(frm), 32'h20E);
`endif

        push(8'h3C);
        res_valid = 1'b1;
        res_data = 8'h11;
        tick();
        res_data = 8'h22;
        tick();
        res_valid = 1'b0;
        repeat (16) @(posedge clk);
        #2 chk("mid_count", 32'(fifo_count), 32'd2);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(res_ready), 32'd0);
        #3 rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("no_resume", 32'(ok), 32'd1);

        tick();
        push(8'h5A);
        res_valid = 1'b1;
        res_data = 8'h6B;
        tick();
        res_valid = 1'b0;
        repeat (12) tick();
        ena = 1'b0;
        chk("drop_busy", 32'(busy), 32'd1);
        repeat (FRAME) tick();
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_count !== 5'd1) ok = 1'b0;
        end
        chk("drop_hold", 32'(ok), 32'd1);
        chk("drop_busy_q", 32'(busy), 32'd1);
        tick();
        ena = 1'b1;
        tick();
        chk("restore_pop", 32'(fifo_count), 32'd0);
        chk("restore_start", 32'(tx), 32'd0);
        wait_idle(2 * FRAME + 10);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
